// File: rtl/ps_mm_ring_writer_pkg.sv
// Shared types for the PacketStream-to-Avalon-MM ring writer: FSM states and descriptor record.
package ps_mm_ring_writer_pkg;

    typedef enum logic [1:0] {
        S_DATA  = 2'd0,
        S_FLUSH = 2'd1,
        S_DESC  = 2'd2
    } state_t;

    // Descriptor fields are sized for the largest supported ring; the top keeps the low bits.
    localparam int DESC_AW = 16;
    localparam int DESC_LW = 32;

    typedef struct packed {
        logic [DESC_AW-1:0] addr;
        logic [DESC_LW-1:0] len;
        logic               err;
    } desc_t;

endpackage

// File: rtl/ps_mty2be.sv
// Converts the stream empty-symbol count into an Avalon byteenable; non-eop beats enable every symbol.
module ps_mty2be #(
    parameter int SYMBOLS = 4,
    parameter int MW      = $clog2(SYMBOLS)
) (
    input  logic [MW-1:0]      mty,
    input  logic               eop,
    output logic [SYMBOLS-1:0] be
);

    // Symbol k is valid on the eop beat only below SYMBOLS - mty.
    always_comb begin
        be = {SYMBOLS{1'b0}};
        for (int k = 0; k < SYMBOLS; k++) begin
            if (!eop) begin
                be[k] = 1'b1;
            end else if (k < (SYMBOLS - int'(mty))) begin
                be[k] = 1'b1;
            end else begin
                be[k] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ps_mm_ring_writer.sv
// Writes PacketStream packets into an Avalon-MM ring and emits one descriptor per packet.
// Build option: define PS_MM_RING_WRITER_DROP_EN to drop (rather than stall) beats when the ring is full.
module ps_mm_ring_writer
    import ps_mm_ring_writer_pkg::*;
#(
    parameter int DWIDTH  = 32,
    parameter int AWIDTH  = 16,
    parameter int SYMBOLS = 4,
    parameter int RWIDTH  = 4,
    parameter int MW      = $clog2(SYMBOLS),
    parameter int LW      = RWIDTH + $clog2(SYMBOLS) + 1
) (
    input  logic                reset,
    input  logic                clk,
    input  logic [AWIDTH-1:0]   base,
    input  logic [RWIDTH:0]     rd_ptr,
    output logic [RWIDTH:0]     wr_ptr,
    input  logic [DWIDTH-1:0]   i_dat,
    input  logic [MW-1:0]       i_mty,
    input  logic                i_val,
    input  logic                i_eop,
    output logic                i_rdy,
    output logic [AWIDTH-1:0]   avm_address,
    output logic [SYMBOLS-1:0]  avm_byteenable,
    output logic                avm_write,
    output logic [DWIDTH-1:0]   avm_writedata,
    input  logic                avm_waitrequest,
    output logic [RWIDTH-1:0]   o_desc_addr,
    output logic [LW-1:0]       o_desc_len,
    output logic                o_desc_err,
    output logic                o_desc_val,
    input  logic                o_desc_rdy
);

`ifdef PS_MM_RING_WRITER_DROP_EN
    localparam logic DROP_EN = 1'b1;
`else
    localparam logic DROP_EN = 1'b0;
`endif

    state_t              state_r;
    logic [RWIDTH:0]     run_ptr_r;
    logic [RWIDTH:0]     wr_ptr_r;
    logic [RWIDTH:0]     cnt_r;
    logic [RWIDTH-1:0]   start_r;
    logic [LW-1:0]       len_r;
    logic                err_r;
    logic                discard_r;
    logic                desc_val_r;
    desc_t               desc_r;

    logic                load_en_s;
    logic                full_s;
    logic                drop_s;
    logic                accept_s;
    logic [SYMBOLS-1:0]  be_s;
    logic [LW-1:0]       beat_bytes_s;
    logic                unused_s;

    ps_mty2be #(.SYMBOLS(SYMBOLS), .MW(MW)) u_mty2be (
        .mty (i_mty),
        .eop (i_eop),
        .be  (be_s)
    );

    assign load_en_s = ~avm_write | ~avm_waitrequest;
    assign full_s    = (run_ptr_r[RWIDTH-1:0] == rd_ptr[RWIDTH-1:0]) &
                       (run_ptr_r[RWIDTH] != rd_ptr[RWIDTH]);
    // A packet that has already filled the whole ring is drained to eop so it can never wait on itself.
    assign drop_s    = discard_r | cnt_r[RWIDTH] | (DROP_EN & full_s);
    assign i_rdy     = (state_r == S_DATA) & load_en_s & (~full_s | drop_s);
    assign accept_s  = i_val & i_rdy;
    assign beat_bytes_s = i_eop ? (LW'(SYMBOLS) - LW'(i_mty)) : LW'(SYMBOLS);

    assign wr_ptr      = wr_ptr_r;
    assign o_desc_val  = desc_val_r;
    assign o_desc_addr = desc_r.addr[RWIDTH-1:0];
    assign o_desc_len  = desc_r.len[LW-1:0];
    assign o_desc_err  = desc_r.err;
    assign unused_s    = ^{desc_r.addr[DESC_AW-1:RWIDTH], desc_r.len[DESC_LW-1:LW]};

    // Packet FSM, ring pointers and the Avalon output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= S_DATA;
            run_ptr_r      <= '0;
            wr_ptr_r       <= '0;
            cnt_r          <= '0;
            start_r        <= '0;
            len_r          <= '0;
            err_r          <= 1'b0;
            discard_r      <= 1'b0;
            desc_val_r     <= 1'b0;
            desc_r         <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
        end else begin
            if (load_en_s) begin
                avm_write <= 1'b0;
            end
            case (state_r)
                S_DATA: begin
                    if (accept_s) begin
                        if (drop_s) begin
                            err_r     <= 1'b1;
                            discard_r <= 1'b1;
                        end else begin
                            avm_write      <= 1'b1;
                            avm_address    <= base | {{(AWIDTH-RWIDTH){1'b0}}, run_ptr_r[RWIDTH-1:0]};
                            avm_byteenable <= be_s;
                            avm_writedata  <= i_dat;
                            run_ptr_r      <= run_ptr_r + (RWIDTH+1)'(1);
                            cnt_r          <= cnt_r + (RWIDTH+1)'(1);
                            len_r          <= len_r + beat_bytes_s;
                        end
                        if (i_eop) begin
                            discard_r <= 1'b0;
                            state_r   <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    // The descriptor is only released once the eop word has left the output register.
                    if (load_en_s) begin
                        desc_r.addr <= DESC_AW'(start_r);
                        desc_r.len  <= DESC_LW'(len_r);
                        desc_r.err  <= err_r;
                        desc_val_r  <= 1'b1;
                        state_r     <= S_DESC;
                    end
                end
                S_DESC: begin
                    if (o_desc_rdy) begin
                        desc_val_r <= 1'b0;
                        wr_ptr_r   <= run_ptr_r;
                        start_r    <= run_ptr_r[RWIDTH-1:0];
                        cnt_r      <= '0;
                        len_r      <= '0;
                        err_r      <= 1'b0;
                        state_r    <= S_DATA;
                    end
                end
                default: begin
                    state_r <= S_DATA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps_mm_ring_writer.sv
// Randomized bench for ps_mm_ring_writer: a packet-level ring model predicts writes and descriptors.
module tb_ps_mm_ring_writer;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int SY = 4;
    localparam int RW = 4;
    localparam int LW = 7;

    logic          reset, clk;
    logic [AW-1:0] base;
    logic [RW:0]   rd_ptr, wr_ptr;
    logic [DW-1:0] i_dat;
    logic [1:0]    i_mty;
    logic          i_val, i_eop, i_rdy;
    logic [AW-1:0] avm_address;
    logic [SY-1:0] avm_byteenable;
    logic          avm_write, avm_waitrequest;
    logic [DW-1:0] avm_writedata;
    logic [RW-1:0] o_desc_addr;
    logic [LW-1:0] o_desc_len;
    logic          o_desc_err, o_desc_val, o_desc_rdy;

    ps_mm_ring_writer #(.DWIDTH(DW), .AWIDTH(AW), .SYMBOLS(SY), .RWIDTH(RW)) dut (
        .reset(reset), .clk(clk), .base(base), .rd_ptr(rd_ptr), .wr_ptr(wr_ptr),
        .i_dat(i_dat), .i_mty(i_mty), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .o_desc_addr(o_desc_addr), .o_desc_len(o_desc_len), .o_desc_err(o_desc_err),
        .o_desc_val(o_desc_val), .o_desc_rdy(o_desc_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model state: committed pointer and the current packet's expectations.
    int            mwp = 0;
    logic [DW-1:0] pkt_dat [32];
    int            pkt_mty;
    int            e_addr, e_len, e_err;
    logic [AW-1:0] exp_a [$];
    logic [DW-1:0] exp_d [$];
    logic [SY-1:0] exp_b [$];
    logic [AW-1:0] obs_a [$];
    logic [DW-1:0] obs_d [$];
    logic [SY-1:0] obs_b [$];

    int   wmode = 0;      // 0: never stall, 1: random stalls, 2: follow force_wait
    logic force_wait = 1'b0;

    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(negedge clk);
            if (wmode == 1)      avm_waitrequest = ($urandom_range(0, 3) == 0);
            else if (wmode == 2) avm_waitrequest = force_wait;
            else                 avm_waitrequest = 1'b0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (avm_write === 1'b1 && avm_waitrequest === 1'b0) begin
                obs_a.push_back(avm_address);
                obs_d.push_back(avm_writedata);
                obs_b.push_back(avm_byteenable);
            end
        end
    end

    // Predict one packet of n beats from the ring rules, using rd_ptr as it stands now.
    task automatic prep_pkt(input int n, input int mty);
        int written, len;
        pkt_mty = mty;
        for (int i = 0; i < n; i++) pkt_dat[i] = $urandom;
        written = (n > 16) ? 16 : n;
`ifdef PS_MM_RING_WRITER_DROP_EN
        begin
            int sp;
            sp = 16 - ((mwp - int'(rd_ptr)) & 31);
            if (written > sp) written = sp;
        end
`endif
        len = 0;
        for (int i = 0; i < written; i++) begin
            exp_a.push_back(16'h0100 | AW'((mwp + i) & 15));
            exp_d.push_back(pkt_dat[i]);
            exp_b.push_back((i == n - 1) ? (4'hF >> mty) : 4'hF);
            len += (i == n - 1) ? (4 - mty) : 4;
        end
        e_addr = mwp & 15;
        e_len  = len;
        e_err  = (written < n) ? 1 : 0;
        mwp    = (mwp + written) & 31;
    endtask

    task automatic send_beats(input int n, input int gaps, input int last_eop);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int k;
            if (gaps != 0) repeat ($urandom_range(0, 1)) @(negedge clk);
            i_val = 1'b1;
            i_dat = pkt_dat[i];
            i_eop = (i == n - 1) && (last_eop != 0);
            i_mty = i_eop ? 2'(pkt_mty) : 2'd0;
            acc = 1'b0;
            k = 0;
            while (!acc && k < 400) begin
                #2;
                acc = i_rdy;
                @(negedge clk);
                k++;
            end
            i_val = 1'b0;
            i_eop = 1'b0;
            if (!acc) begin
                chk("rdy_timeout", 64'd0, 64'd1);
                return;
            end
        end
    endtask

    task automatic end_pkt(input int hold, input int lat);
        int k, m;
        k = 0;
        while (o_desc_val !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("desc_val", o_desc_val, 1);
        if (lat >= 0) chk("desc_lat", k, lat);
        chk("desc_addr", o_desc_addr, e_addr);
        chk("desc_len", o_desc_len, e_len);
        chk("desc_err", o_desc_err, e_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("desc_hold", o_desc_val, 1);
            chk("desc_hold_len", o_desc_len, e_len);
            #2;
            chk("rdy_in_desc", i_rdy, 0);
        end
        o_desc_rdy = 1'b1;
        @(negedge clk);
        o_desc_rdy = 1'b0;
        chk("wr_ptr", wr_ptr, mwp);
        chk("desc_clr", o_desc_val, 0);
        chk("n_writes", obs_a.size(), exp_a.size());
        m = (obs_a.size() < exp_a.size()) ? obs_a.size() : exp_a.size();
        for (int i = 0; i < m; i++) begin
            chk("wr_addr", obs_a[i], exp_a[i]);
            chk("wr_data", obs_d[i], exp_d[i]);
            chk("wr_be", obs_b[i], exp_b[i]);
        end
        obs_a.delete(); obs_d.delete(); obs_b.delete();
        exp_a.delete(); exp_d.delete(); exp_b.delete();
    endtask

    // Holds waitrequest for five cycles while the second word of the packet sits in the output register.
    task automatic stall_probe();
        logic [AW-1:0] t0, t1;
        bit found;
        t0 = 16'h0100 | AW'(e_addr);
        t1 = 16'h0100 | AW'((e_addr + 1) & 15);
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            #1;
            found = (avm_write === 1'b1) && (avm_address === t0);
        end
        chk("stall_found", found, 1);
        force_wait = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            chk("stall_wr", avm_write, 1);
            chk("stall_addr", avm_address, t1);
            chk("stall_data", avm_writedata, pkt_dat[1]);
            chk("stall_rdy", i_rdy, 0);
        end
        force_wait = 1'b0;
    endtask

    initial begin
        reset = 1'b1; base = 16'h0100; rd_ptr = '0;
        i_val = 1'b0; i_dat = '0; i_mty = '0; i_eop = 1'b0; o_desc_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_avm_write", avm_write, 0);
        chk("rst_avm_addr", avm_address, 0);
        chk("rst_desc_val", o_desc_val, 0);
        reset = 1'b0;
        @(negedge clk);

        // 3 beats, mty=1
        rd_ptr = 5'(mwp); prep_pkt(3, 1); send_beats(3, 0, 1); end_pkt(0, 1);

        // waitrequest held on beat 2
        rd_ptr = 5'(mwp); prep_pkt(3, 0); wmode = 2;
        fork
            send_beats(3, 0, 1);
            stall_probe();
        join
        wmode = 0;
        end_pkt(0, -1);

        // bring the pointer to 0x0E, then a packet that wraps the ring
        rd_ptr = 5'(mwp); prep_pkt(8, 0); send_beats(8, 0, 1); end_pkt(0, -1);
        rd_ptr = 5'(mwp); prep_pkt(4, 0); send_beats(4, 0, 1); end_pkt(0, -1);

        // 12 words unread: 4 fit, then stall (or drop) until the consumer frees 2
        rd_ptr = 5'((mwp - 12) & 31); prep_pkt(6, 0);
        fork
            send_beats(6, 0, 1);
            begin
                repeat (20) @(negedge clk);
`ifndef PS_MM_RING_WRITER_DROP_EN
                #2;
                chk("full_nwr", obs_a.size(), 4);
                chk("full_rdy", i_rdy, 0);
`endif
                repeat (10) @(negedge clk);
                rd_ptr = rd_ptr + 5'd2;
            end
        join
        end_pkt(0, -1);

        // oversize packet is truncated at the ring size
        rd_ptr = 5'(mwp); prep_pkt(20, 0); send_beats(20, 0, 1); end_pkt(0, -1);

        // random packets with random slave stalls and stream gaps
        wmode = 1;
        for (int p = 0; p < 10; p++) begin
            int n;
            n = $urandom_range(1, 7);
            rd_ptr = 5'(mwp);
            prep_pkt(n, $urandom_range(0, 3));
            send_beats(n, 1, 1);
            end_pkt(0, -1);
        end
        wmode = 0;
        @(negedge clk);

        // descriptor back-pressure
        rd_ptr = 5'(mwp); prep_pkt(2, 3); send_beats(2, 0, 1); end_pkt(10, -1);

        // reset in the middle of a packet
        rd_ptr = 5'(mwp); prep_pkt(5, 0); send_beats(2, 0, 0);
        reset = 1'b1;
        #2;
        chk("mid_rst_write", avm_write, 0);
        chk("mid_rst_wr_ptr", wr_ptr, 0);
        chk("mid_rst_be", avm_byteenable, 0);
        chk("mid_rst_desc", o_desc_val, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        obs_a.delete(); obs_d.delete(); obs_b.delete();
        exp_a.delete(); exp_d.delete(); exp_b.delete();
        mwp = 0; rd_ptr = '0;
        prep_pkt(2, 0); send_beats(2, 0, 1); end_pkt(0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
